tick_gen_mc: RTL and testbench

- Multi-channel programmable tick generator: CH_N independent counters, each producing a one-cycle impulse every DIV clock cycles.
- DIV is writable at run time per channel. Each channel runs periodic or one-shot.
- Serves as the common timebase source for timer, display-scan and debounce logic in the FPGA design.
- Generalises the single fixed-period divider to runtime divisors, multiple channels, enable, one-shot mode and global phase alignment.

---
 rtl/tick_gen_mc.sv | 74 +++++++
 tb/tb_tick_gen_mc.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/tick_gen_mc.sv
// tick_gen_mc: multi-channel programmable tick generator, each channel periodic or one-shot
module tick_gen_mc #(
  parameter int CH_N = 4,
  parameter int CNT_W = 26,
  parameter int DIV_RST = 50000000,
  localparam int CH_W = (CH_N > 1) ? $clog2(CH_N) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH_N-1:0]  en,
  input  logic [CH_N-1:0]  mode,
  input  logic             sync_clr,
  input  logic             load,
  input  logic [CH_W-1:0]  load_ch,
  input  logic [CNT_W-1:0] load_div,
  output logic [CH_N-1:0]  imp,
  output logic [CH_N-1:0]  busy
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q [CH_N];
  state_t           state_d [CH_N];
  logic [CNT_W-1:0] div_q [CH_N];
  logic [CNT_W-1:0] div_d [CH_N];
  logic [CNT_W-1:0] cnt_q [CH_N];
  logic [CNT_W-1:0] cnt_d [CH_N];
  logic [CNT_W-1:0] div_eff [CH_N];
  logic [CH_N-1:0]  mode_q, mode_d, at_end, wr;
  always_comb begin
    for (int i = 0; i < CH_N; i++) begin
      div_eff[i] = (div_q[i] == '0) ? CNT_W'(1) : div_q[i];
      at_end[i] = cnt_q[i] == div_eff[i] - CNT_W'(1);
      imp[i] = (state_q[i] == RUN) && at_end[i];
      busy[i] = state_q[i] == RUN;
      wr[i] = load && (load_ch == CH_W'(i));
    end
  end
  // cnt defaults to zero: every path except a plain count step restarts the phase
  always_comb begin
    for (int i = 0; i < CH_N; i++) begin
      div_d[i] = wr[i] ? load_div : div_q[i];
      mode_d[i] = mode_q[i];
      state_d[i] = state_q[i];
      cnt_d[i] = '0;
      if (!en[i])
        state_d[i] = IDLE;
      else if (state_q[i] == IDLE) begin
        state_d[i] = RUN;
        mode_d[i] = mode[i];
      end else if (state_q[i] == RUN) begin
        if (imp[i] && mode_q[i])
          state_d[i] = DONE;
        else if (!wr[i] && !sync_clr && !at_end[i])
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH_N; i++) begin
        state_q[i] <= IDLE;
        div_q[i] <= CNT_W'(DIV_RST);
        cnt_q[i] <= '0;
      end
      mode_q <= '0;
    end else begin
      for (int i = 0; i < CH_N; i++) begin
        state_q[i] <= state_d[i];
        div_q[i] <= div_d[i];
        cnt_q[i] <= cnt_d[i];
      end
      mode_q <= mode_d;
    end
  end
endmodule

// File: tb/tb_tick_gen_mc.sv
// tb_tick_gen_mc: directed and random stimulus against a phase-time reference model of tick_gen_mc
module tb_tick_gen_mc;
  localparam int CH_N = 5;
  localparam int CNT_W = 8;
  localparam int DIV_RST = 6;
  localparam int CH_W = 3;
  logic clk = 0, reset = 0, sync_clr = 0, load = 0;
  logic [CH_N-1:0] en = '0, mode = '0, imp, busy;
  logic [CH_W-1:0] load_ch = '0;
  logic [CNT_W-1:0] load_div = '0;
  int checks = 0, errors = 0;
  // model: st 0=idle 1=run 2=done; t = cycles since the phase last restarted
  int m_st [CH_N];
  int m_div [CH_N];
  int m_t [CH_N];
  bit m_mq [CH_N];

  tick_gen_mc #(.CH_N(CH_N), .CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .sync_clr(sync_clr),
    .load(load), .load_ch(load_ch), .load_div(load_div), .imp(imp), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [CH_N-1:0] exp_imp();
    logic [CH_N-1:0] r = '0;
    for (int i = 0; i < CH_N; i++) begin
      int d = (m_div[i] == 0) ? 1 : m_div[i];
      r[i] = (m_st[i] == 1) && ((m_t[i] + 1) % d == 0);
    end
    return r;
  endfunction

  function automatic logic [CH_N-1:0] exp_busy();
    logic [CH_N-1:0] r = '0;
    for (int i = 0; i < CH_N; i++) r[i] = m_st[i] == 1;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < CH_N; i++) begin
      m_st[i] = 0; m_div[i] = DIV_RST; m_t[i] = 0; m_mq[i] = 0;
    end
  endtask

  task automatic model_step();
    logic [CH_N-1:0] ip = exp_imp();
    for (int i = 0; i < CH_N; i++) begin
      bit wr = load && (int'(load_ch) == i);
      if (wr) m_div[i] = int'(load_div);
      if (!en[i]) begin
        m_st[i] = 0; m_t[i] = 0;
      end else if (m_st[i] == 0) begin
        m_st[i] = 1; m_t[i] = 0; m_mq[i] = mode[i];
      end else if (m_st[i] == 1) begin
        if (ip[i] && m_mq[i]) begin
          m_st[i] = 2; m_t[i] = 0;
        end else if (wr || sync_clr) m_t[i] = 0;
        else m_t[i]++;
      end
    end
  endtask

  task automatic check(input string tag);
    logic [CH_N-1:0] ei = exp_imp(), eb = exp_busy();
    checks += 2;
    assert (imp === ei) else begin
      errors++;
      $error("FAIL %s imp got %b want %b", tag, imp, ei);
    end
    assert (busy === eb) else begin
      errors++;
      $error("FAIL %s busy got %b want %b", tag, busy, eb);
    end
  endtask

  task automatic cyc(input string tag, input int n = 1);
    repeat (n) begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      load = 0;
      sync_clr = 0;
      check(tag);
    end
  endtask

  task automatic wr_div(input int ch, input int d);
    load = 1; load_ch = CH_W'(ch); load_div = CNT_W'(d);
  endtask

  initial begin
    model_reset();
    #1 reset = 1;
    #1 check("reset_hold");
    @(negedge clk) reset = 0;
    cyc("post_reset", 2);
    wr_div(0, 5); cyc("load_ch0");
    en[0] = 1; cyc("periodic_div5", 16);
    wr_div(1, 0); cyc("load_div0");
    en[1] = 1; cyc("div0_run", 4);
    en[1] = 0; cyc("div0_stop", 2);
    wr_div(1, 1); cyc("load_div1");
    en[1] = 1; cyc("div1_run", 4);
    en[1] = 0; cyc("div1_stop", 2);
    wr_div(2, 3); mode[2] = 1; cyc("load_ch2");
    en[2] = 1; cyc("oneshot_first", 7);
    en[2] = 0; cyc("oneshot_drop");
    en[2] = 1; mode[2] = 0; cyc("oneshot_second", 7);
    en = '0; cyc("all_off");
    wr_div(0, 7); cyc("load_div7");
    en[0] = 1; cyc("div7_run", 6);
    wr_div(0, 3); cyc("reload_div3");
    cyc("div3_run", 9);
    wr_div(5, 2); cyc("oob_ch5");
    wr_div(7, 1); cyc("oob_ch7");
    cyc("oob_after", 6);
    en = '0; wr_div(0, 4); cyc("align_load0");
    wr_div(3, 4); cyc("align_load3");
    en[0] = 1; cyc("align_en0", 2);
    en[3] = 1; cyc("align_en3", 3);
    sync_clr = 1; cyc("sync_clr");
    repeat (12) begin
      cyc("aligned");
      checks++;
      assert (imp[0] === imp[3]) else begin
        errors++;
        $error("FAIL align imp0 %b imp3 %b", imp[0], imp[3]);
      end
    end
    wr_div(1, 3); en = 5'b00111; cyc("pre_reset_run", 5);
    @(posedge clk);
    model_step();
    #2 reset = 1;
    model_reset();
    #1 check("async_reset");
    @(negedge clk) reset = 0; en = '1; mode = '0;
    check("reset_release");
    cyc("div_rst_period", 15);
    repeat (400) begin
      en = CH_N'($urandom) | CH_N'($urandom);
      mode = CH_N'($urandom);
      sync_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 5) == 0)
        wr_div($urandom_range(0, 7), ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 9));
      cyc("random");
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
